// File: rtl/rs232_pkg.sv
// Shared definitions for the RS232 receive-side frame parser.
//   state_t          : parser FSM states
//   SOF_BYTE_DEFAULT : default start-of-frame marker
//   MAX_LEN_DEFAULT  : default maximum payload length in bytes
//   STOP_BIT_IDX     : bit of the deserializer word holding the sampled stop bit
package rs232_pkg;
    typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CHK, EMIT} state_t;

    localparam logic [7:0] SOF_BYTE_DEFAULT = 8'hA5;
    localparam int         MAX_LEN_DEFAULT  = 16;
    localparam int         STOP_BIT_IDX     = 8;
endpackage

// File: rtl/rs232_frame_buffer.sv
// Payload holding buffer: DEPTH x 8 register file.
//   clk   : clock
//   we    : write enable (synchronous write of wdata at waddr)
//   waddr : write address
//   wdata : write data
//   raddr : read address (combinational read)
//   rdata : read data
module rs232_frame_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);
    // Contents need no reset: a frame is only read back after it was fully written.
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/rs232_rx_frame_parser.sv
// Frame parser behind the RS232 deserializer. Drains the show-ahead RX FIFO,
// extracts SOF/LEN/payload/XOR-checksum frames, buffers the payload and
// releases it on a valid/ready stream only once the checksum matches.
//   clk, reset          : clock, synchronous active-high reset
//   fifo_read_available : registered FIFO status, [7] full, [6:0] words used
//   received_data       : head-of-FIFO word, [7:0] data, [8] stop bit
//   receive_data_en     : FIFO pop strobe
//   m_data/m_valid/m_last/m_ready : payload byte stream
//   frame_good/frame_bad : one-cycle frame verdict pulses
//   err_count           : saturating dropped-frame counter
//   busy                : parser is away from HUNT
module rs232_rx_frame_parser
    import rs232_pkg::*;
#(
    parameter int         DATA_WIDTH = 9,
    parameter logic [7:0] SOF_BYTE   = SOF_BYTE_DEFAULT,
    parameter int         MAX_LEN    = MAX_LEN_DEFAULT,
    parameter int         LEN_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            fifo_read_available,
    input  logic [DATA_WIDTH-1:0] received_data,
    output logic                  receive_data_en,
    output logic [7:0]            m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  frame_good,
    output logic                  frame_bad,
    output logic [7:0]            err_count,
    output logic                  busy
);
    localparam int         BUF_AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t               state, state_n;
    logic [LEN_WIDTH-1:0] len, wr_ptr, rd_ptr;
    logic [7:0]           chk, rx_byte, buf_rdata;
    logic [6:0]           used;
    logic                 rx_stop_ok, pop_prev, can_pop, pop;
    logic                 buf_we, good_n, bad_n, hs;

    assign rx_byte    = received_data[7:0];
    assign rx_stop_ok = received_data[STOP_BIT_IDX];

    // The status word lags the FIFO by a cycle: a single visible word may
    // already have been taken by last cycle's pop.
    assign used    = fifo_read_available[6:0];
    assign can_pop = fifo_read_available[7] || (used >= 7'd2) || (used == 7'd1 && !pop_prev);
    assign pop     = can_pop && (state != EMIT) && !reset;
    assign receive_data_en = pop;

    assign m_valid = (state == EMIT);
    assign m_data  = m_valid ? buf_rdata : 8'h00;
    assign m_last  = m_valid && (rd_ptr == len - 1'b1);
    assign hs      = m_valid && m_ready;
    assign busy    = (state != HUNT);

    always_comb begin
        state_n = state;
        buf_we  = 1'b0;
        good_n  = 1'b0;
        bad_n   = 1'b0;
        unique case (state)
            HUNT: begin
                // Bad-stop words are dropped here without a verdict.
                if (pop && rx_stop_ok && rx_byte == SOF_BYTE) state_n = LEN;
            end
            LEN: begin
                if (pop) begin
                    if (!rx_stop_ok || rx_byte == 8'h00 || rx_byte > MAX_LEN_B) begin
                        bad_n   = 1'b1;
                        state_n = HUNT;
                    end else begin
                        state_n = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (pop) begin
                    if (!rx_stop_ok) begin
                        bad_n   = 1'b1;
                        state_n = HUNT;
                    end else begin
                        buf_we = 1'b1;
                        if (wr_ptr + 1'b1 == len) state_n = CHK;
                    end
                end
            end
            CHK: begin
                if (pop) begin
                    if (!rx_stop_ok || rx_byte != chk) begin
                        bad_n   = 1'b1;
                        state_n = HUNT;
                    end else begin
                        good_n  = 1'b1;
                        state_n = EMIT;
                    end
                end
            end
            EMIT: begin
                if (hs && m_last) state_n = HUNT;
            end
            default: state_n = HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= HUNT;
            len        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            chk        <= 8'h00;
            pop_prev   <= 1'b0;
            frame_good <= 1'b0;
            frame_bad  <= 1'b0;
            err_count  <= 8'h00;
        end else begin
            state      <= state_n;
            pop_prev   <= pop;
            frame_good <= good_n;
            frame_bad  <= bad_n;
            if (bad_n && err_count != 8'hFF) err_count <= err_count + 8'd1;
            // The length byte seeds the checksum.
            if (state == LEN && state_n == PAYLOAD) begin
                len    <= rx_byte[LEN_WIDTH-1:0];
                chk    <= rx_byte;
                wr_ptr <= '0;
            end
            if (buf_we) begin
                chk    <= chk ^ rx_byte;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (state == CHK) rd_ptr <= '0;
            if (hs) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    rs232_frame_buffer #(
        .DEPTH (MAX_LEN),
        .AW    (BUF_AW)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (wr_ptr[BUF_AW-1:0]),
        .wdata (rx_byte),
        .raddr (rd_ptr[BUF_AW-1:0]),
        .rdata (buf_rdata)
    );
endmodule

// File: tb/tb_rs232_rx_frame_parser.sv
module tb_rs232_rx_frame_parser;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] fifo_read_available;
    logic [8:0] received_data;
    logic       receive_data_en;
    logic [7:0] m_data;
    logic       m_valid, m_last, m_ready;
    logic       frame_good, frame_bad;
    logic [7:0] err_count;
    logic       busy;

    int n_total = 0;
    int n_bad   = 0;

    // FIFO contents: written only by the stimulus, consumed via rd_idx.
    logic [8:0] push_q[$];
    int rd_idx = 0;
    int vis    = 0;

    // Monitor state (written only by the monitor process).
    logic       pop_now = 1'b0;
    logic [8:0] hs_q[$];
    int good_cnt = 0, bad_cnt = 0, underflow = 0, pop_in_emit = 0, stall_viol = 0;
    logic       stalled = 1'b0;
    logic [7:0] held_data = 8'h00;
    logic       held_last = 1'b0;

    always #5 clk = ~clk;

    rs232_rx_frame_parser dut (
        .clk                 (clk),
        .reset               (reset),
        .fifo_read_available (fifo_read_available),
        .received_data       (received_data),
        .receive_data_en     (receive_data_en),
        .m_data              (m_data),
        .m_valid             (m_valid),
        .m_last              (m_last),
        .m_ready             (m_ready),
        .frame_good          (frame_good),
        .frame_bad           (frame_bad),
        .err_count           (err_count),
        .busy                (busy)
    );

    // Show-ahead FIFO whose status word reports last cycle's occupancy.
    always @(posedge clk) begin
        int sz;
        #1;
        sz = push_q.size() - rd_idx;
        fifo_read_available = (sz >= 128) ? {1'b1, 7'd127} : {1'b0, 7'(sz)};
        if (pop_now && sz > 0) rd_idx = rd_idx + 1;
        vis = push_q.size() - rd_idx;
        received_data = (vis > 0) ? push_q[rd_idx] : 9'h000;
    end

    always @(negedge clk) begin
        pop_now = receive_data_en;
        if (receive_data_en && vis == 0) underflow++;
        if (receive_data_en && m_valid) pop_in_emit++;
        if (m_valid && m_ready) hs_q.push_back({m_last, m_data});
        if (frame_good) good_cnt++;
        if (frame_bad) bad_cnt++;
        if (frame_good && frame_bad) stall_viol++;
        if (stalled && (!m_valid || m_data !== held_data || m_last !== held_last)) stall_viol++;
        stalled   = m_valid && !m_ready;
        held_data = m_data;
        held_last = m_last;
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic push_b(input logic [7:0] b, input logic stop = 1'b1);
        push_q.push_back({stop, b});
    endtask

    task automatic wait_idle(input int budget, input string name);
        int idle = 0;
        int n = 0;
        while (idle < 4 && n < budget) begin
            tick(1);
            n++;
            if ((push_q.size() - rd_idx) == 0 && !busy && !frame_good && !frame_bad) idle++;
            else idle = 0;
        end
        n_total++;
        if (idle < 4) begin
            n_bad++;
            $display("FAIL %s_idle_timeout got busy=%0b left=%0d want idle within %0d cycles",
                     name, busy, push_q.size() - rd_idx, budget);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; m_ready = 1'b1;
        tick(3);
        n_total++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL rst_m_valid got %b want 0", m_valid); end
        n_total++; if (m_data !== 8'h00) begin n_bad++; $display("FAIL rst_m_data got %h want 00", m_data); end
        n_total++; if (m_last !== 1'b0) begin n_bad++; $display("FAIL rst_m_last got %b want 0", m_last); end
        n_total++; if (err_count !== 8'h00) begin n_bad++; $display("FAIL rst_err got %h want 00", err_count); end
        n_total++; if (busy !== 1'b0 || frame_good !== 1'b0 || frame_bad !== 1'b0)
            begin n_bad++; $display("FAIL rst_flags got busy=%b good=%b bad=%b want 0", busy, frame_good, frame_bad); end
        reset = 1'b0;
        tick(2);
        n_total++; if (receive_data_en !== 1'b0 || busy !== 1'b0)
            begin n_bad++; $display("FAIL rst_idle got en=%b busy=%b want 0", receive_data_en, busy); end
    endtask

    task automatic test_good_frame();
        logic [8:0] exp [3] = '{9'h011, 9'h022, 9'h133};
        int base = hs_q.size();
        int g0 = good_cnt, b0 = bad_cnt;
        push_b(8'hA5); push_b(8'h03); push_b(8'h11); push_b(8'h22); push_b(8'h33); push_b(8'h03);
        wait_idle(100, "good");
        n_total++; if (hs_q.size() - base !== 3) begin n_bad++; $display("FAIL good_count got %0d want 3", hs_q.size() - base); end
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (hs_q[base+i] !== exp[i]) begin n_bad++; $display("FAIL good_byte%0d got %h want %h", i, hs_q[base+i], exp[i]); end
        end
        n_total++; if (good_cnt - g0 !== 1) begin n_bad++; $display("FAIL good_pulse got %0d want 1", good_cnt - g0); end
        n_total++; if (bad_cnt - b0 !== 0) begin n_bad++; $display("FAIL good_nobad got %0d want 0", bad_cnt - b0); end
        n_total++; if (err_count !== 8'h00) begin n_bad++; $display("FAIL good_err got %h want 00", err_count); end
    endtask

    task automatic test_bad_checksum();
        int base = hs_q.size();
        int g0 = good_cnt, b0 = bad_cnt;
        push_b(8'hA5); push_b(8'h03); push_b(8'h11); push_b(8'h22); push_b(8'h33); push_b(8'h04);
        push_b(8'hA5); push_b(8'h01); push_b(8'h7E); push_b(8'h7F);
        wait_idle(100, "badchk");
        n_total++; if (hs_q.size() - base !== 1) begin n_bad++; $display("FAIL badchk_count got %0d want 1", hs_q.size() - base); end
        n_total++; if (hs_q[base] !== 9'h17E) begin n_bad++; $display("FAIL badchk_byte got %h want 17e", hs_q[base]); end
        n_total++; if (bad_cnt - b0 !== 1) begin n_bad++; $display("FAIL badchk_bad got %0d want 1", bad_cnt - b0); end
        n_total++; if (good_cnt - g0 !== 1) begin n_bad++; $display("FAIL badchk_good got %0d want 1", good_cnt - g0); end
        n_total++; if (err_count !== 8'h01) begin n_bad++; $display("FAIL badchk_err got %h want 01", err_count); end
    endtask

    task automatic test_bad_len();
        int base = hs_q.size();
        int g0 = good_cnt, b0 = bad_cnt;
        push_b(8'h00); push_b(8'hFF); push_b(8'hA5); push_b(8'h00);
        push_b(8'hA5); push_b(8'h11);
        wait_idle(100, "badlen");
        n_total++; if (bad_cnt - b0 !== 2) begin n_bad++; $display("FAIL badlen_bad got %0d want 2", bad_cnt - b0); end
        n_total++; if (good_cnt - g0 !== 0 || hs_q.size() != base)
            begin n_bad++; $display("FAIL badlen_out got good=%0d hs=%0d want 0 0", good_cnt - g0, hs_q.size() - base); end
        n_total++; if (err_count !== 8'h03) begin n_bad++; $display("FAIL badlen_err got %h want 03", err_count); end
    endtask

    task automatic test_stop_bit();
        int base = hs_q.size();
        int g0 = good_cnt, b0 = bad_cnt;
        push_b(8'hA5); push_b(8'h02); push_b(8'h10, 1'b0);
        // A bad-stop SOF in HUNT must not open a frame; 02 is then junk.
        push_b(8'hA5, 1'b0); push_b(8'h02);
        push_b(8'hA5); push_b(8'h01); push_b(8'h55); push_b(8'h54);
        wait_idle(100, "stop");
        n_total++; if (bad_cnt - b0 !== 1) begin n_bad++; $display("FAIL stop_bad got %0d want 1", bad_cnt - b0); end
        n_total++; if (good_cnt - g0 !== 1) begin n_bad++; $display("FAIL stop_good got %0d want 1", good_cnt - g0); end
        n_total++; if (hs_q.size() - base !== 1 || hs_q[base] !== 9'h155)
            begin n_bad++; $display("FAIL stop_out got n=%0d b=%h want 1 155", hs_q.size() - base, hs_q[base]); end
        n_total++; if (err_count !== 8'h04) begin n_bad++; $display("FAIL stop_err got %h want 04", err_count); end
    endtask

    task automatic test_backpressure();
        logic [8:0] exp [5] = '{9'h001, 9'h002, 9'h003, 9'h104, 9'h1AA};
        int base = hs_q.size();
        int s0 = stall_viol, e0 = pop_in_emit;
        int n = 0;
        m_ready = 1'b0;
        push_b(8'hA5); push_b(8'h04); push_b(8'h01); push_b(8'h02); push_b(8'h03); push_b(8'h04); push_b(8'h00);
        push_b(8'hA5); push_b(8'h01); push_b(8'hAA); push_b(8'hAB);
        while (!m_valid && n < 100) begin tick(1); n++; end
        n_total++; if (m_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid_timeout got %b want 1", m_valid); end
        n_total++; if (push_q.size() - rd_idx !== 4) begin n_bad++; $display("FAIL bp_queued got %0d want 4", push_q.size() - rd_idx); end
        m_ready = 1'b1; tick(1);
        m_ready = 1'b0; tick(1);
        n_total++; if (m_data !== 8'h02 || m_valid !== 1'b1 || m_last !== 1'b0)
            begin n_bad++; $display("FAIL bp_hold got v=%b d=%h l=%b want 1 02 0", m_valid, m_data, m_last); end
        tick(1);
        m_ready = 1'b1;
        wait_idle(200, "bp");
        n_total++; if (hs_q.size() - base !== 5) begin n_bad++; $display("FAIL bp_count got %0d want 5", hs_q.size() - base); end
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if (hs_q[base+i] !== exp[i]) begin n_bad++; $display("FAIL bp_byte%0d got %h want %h", i, hs_q[base+i], exp[i]); end
        end
        n_total++; if (stall_viol - s0 !== 0) begin n_bad++; $display("FAIL bp_stable got %0d violations want 0", stall_viol - s0); end
        n_total++; if (pop_in_emit - e0 !== 0) begin n_bad++; $display("FAIL bp_emit_pop got %0d want 0", pop_in_emit - e0); end
    endtask

    task automatic test_trickle();
        logic [7:0] bytes [5] = '{8'hA5, 8'h02, 8'h5A, 8'h5B, 8'h03};
        int base = hs_q.size();
        int u0 = underflow;
        for (int i = 0; i < 5; i++) begin push_b(bytes[i]); tick(3); end
        wait_idle(100, "trickle");
        n_total++; if (underflow - u0 !== 0) begin n_bad++; $display("FAIL trickle_double_pop got %0d want 0", underflow - u0); end
        n_total++; if (hs_q.size() - base !== 2 || hs_q[base] !== 9'h05A || hs_q[base+1] !== 9'h15B)
            begin n_bad++; $display("FAIL trickle_out got n=%0d %h %h want 2 05a 15b", hs_q.size() - base, hs_q[base], hs_q[base+1]); end
    endtask

    task automatic test_saturate();
        int b0 = bad_cnt;
        for (int i = 0; i < 300; i++) begin push_b(8'hA5); push_b(8'h00); end
        wait_idle(3000, "sat");
        n_total++; if (bad_cnt - b0 !== 300) begin n_bad++; $display("FAIL sat_bad got %0d want 300", bad_cnt - b0); end
        n_total++; if (err_count !== 8'hFF) begin n_bad++; $display("FAIL sat_err got %h want ff", err_count); end
    endtask

    task automatic test_reset_mid_frame();
        int n = 0;
        int b0, base;
        push_b(8'hA5); push_b(8'h05); push_b(8'h01); push_b(8'h02);
        while (!((push_q.size() - rd_idx) == 0 && busy) && n < 50) begin tick(1); n++; end
        n_total++; if (busy !== 1'b1) begin n_bad++; $display("FAIL midrst_reach got busy=%b want 1", busy); end
        b0 = bad_cnt;
        reset = 1'b1; tick(1);
        n_total++; if (err_count !== 8'h00) begin n_bad++; $display("FAIL midrst_err got %h want 00", err_count); end
        n_total++; if (busy !== 1'b0 || m_valid !== 1'b0 || m_data !== 8'h00 || m_last !== 1'b0)
            begin n_bad++; $display("FAIL midrst_out got busy=%b v=%b d=%h l=%b want 0", busy, m_valid, m_data, m_last); end
        n_total++; if (frame_good !== 1'b0 || frame_bad !== 1'b0 || receive_data_en !== 1'b0)
            begin n_bad++; $display("FAIL midrst_flags got g=%b b=%b en=%b want 0", frame_good, frame_bad, receive_data_en); end
        reset = 1'b0;
        base = hs_q.size();
        push_b(8'hA5); push_b(8'h01); push_b(8'h33); push_b(8'h32);
        wait_idle(100, "midrst");
        n_total++; if (bad_cnt - b0 !== 0) begin n_bad++; $display("FAIL midrst_nobad got %0d want 0", bad_cnt - b0); end
        n_total++; if (hs_q.size() - base !== 1 || hs_q[base] !== 9'h133)
            begin n_bad++; $display("FAIL midrst_frame got n=%0d %h want 1 133", hs_q.size() - base, hs_q[base]); end
        n_total++; if (err_count !== 8'h00) begin n_bad++; $display("FAIL midrst_err_after got %h want 00", err_count); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_bad_len();
        test_stop_bit();
        test_backpressure();
        test_trickle();
        test_saturate();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/rs232_rx_frame_parser.md
Name: rs232_rx_frame_parser

Overview:
- Sits directly downstream of the RS232 input deserializer. Drains its show-ahead RX FIFO through the fifo_read_available / received_data / receive_data_en interface.
- Extracts framed packets (SOF, LEN, payload, XOR checksum) and buffers each payload internally.
- Releases a payload on a valid/ready byte stream only after the checksum verifies. Bad frames are dropped and counted.

Parameters:
- DATA_WIDTH, 9, width of received_data; [7:0] is the data byte, [8] is the sampled stop bit.
- SOF_BYTE, 8'hA5, start-of-frame marker.
- MAX_LEN, 16, maximum payload bytes per frame.
- LEN_WIDTH, 5, width of the length/pointer counters (must hold MAX_LEN).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- fifo_read_available  in  8  registered RX FIFO status from deserializer; [7] full, [6:0] words used.
- received_data  in  DATA_WIDTH  show-ahead head-of-FIFO word.
- receive_data_en  out  1  pop strobe to the RX FIFO.
- m_data  out  8  payload byte.
- m_valid  out  1  m_data valid.
- m_last  out  1  final payload byte of a frame.
- m_ready  in  1  downstream accept.
- frame_good  out  1  one-cycle pulse when a frame passes checksum.
- frame_bad  out  1  one-cycle pulse when a frame is dropped.
- err_count  out  8  saturating count of dropped frames.
- busy  out  1  high in any state other than HUNT.

Behaviour:
- Reset: all outputs 0, state HUNT, counters/pointers 0, checksum 0. Reset mid-frame or mid-emit discards everything; no frame_bad is raised.
- Pop rule: a byte is consumed in cycle N when receive_data_en=1 and received_data is sampled in the same cycle. Because fifo_read_available lags by one cycle:
  - pop allowed if used>=2;
  - pop allowed if used==1 and no pop occurred in cycle N-1;
  - otherwise no pop.
  - receive_data_en is never asserted in EMIT.
- Byte error: a popped word with [8]==0 (bad stop bit). In LEN/PAYLOAD/CHK it sends the FSM to HUNT with frame_bad. In HUNT the word is silently discarded.
- States and transitions:
  - HUNT: pop continuously. Byte==SOF_BYTE goes to LEN; any other byte is discarded.
  - LEN: pop one byte L. If L==0 or L>MAX_LEN, go to HUNT with frame_bad. Otherwise store L, set chk=L, wr_ptr=0, go to PAYLOAD.
  - PAYLOAD: each pop writes buf[wr_ptr] and updates chk^=byte, wr_ptr++. When wr_ptr reaches L, go to CHK.
  - CHK: pop one byte C. If C==chk, pulse frame_good and go to EMIT with rd_ptr=0. Otherwise pulse frame_bad and go to HUNT.
  - EMIT: m_valid=1, m_data=buf[rd_ptr], m_last=(rd_ptr==L-1). On m_valid&m_ready, rd_ptr++. Handshake on the last byte returns to HUNT in the next cycle.
- Output handshake: m_data/m_last are held stable while m_valid&~m_ready. m_valid drops the cycle after the last handshake.
- SOF_BYTE appearing inside LEN, PAYLOAD, or CHK is treated as ordinary data (no resync).
- frame_good and frame_bad never assert in the same cycle.
- err_count increments on each frame_bad and saturates at 8'hFF.
- Latency: the first m_valid occurs 1 cycle after the CHK byte is popped.
- Backpressure: while in EMIT the RX FIFO fills. Overflow is the deserializer's concern and is not detected here.

Decomposition:
- Shared package rs232_pkg holds:
  - state enum {HUNT, LEN, PAYLOAD, CHK, EMIT};
  - SOF_BYTE default and MAX_LEN;
  - stop-bit index constant.
- One sub-module: rs232_frame_buffer. It is a MAX_LEN x 8 register file with a synchronous write port and a combinational read port addressed by rd_ptr.

Test Plan:
- Stream A5 03 11 22 33 03 (chk=03^11^22^33=03), m_ready=1: m_data 11,22,33 with m_last on 33; frame_good=1 once; err_count=0.
- Same frame with checksum 04: no m_valid; frame_bad pulse; err_count=1. Then a following valid frame A5 01 7E 7F is emitted as 7E with m_last.
- Garbage 00 FF A5 00: the two leading bytes are discarded; L=0 triggers frame_bad; the FSM returns to HUNT. A5 11 (L=17) also triggers frame_bad.
- Payload byte with stop bit 0 during PAYLOAD: frame_bad; HUNT; err_count increments. A stop-bit-0 byte while in HUNT: no frame_bad.
- Emit with m_ready toggling 1,0,0,1 and a 4-byte frame, while more bytes sit queued in the RX FIFO: data is held stable during stalls; no receive_data_en during EMIT; the next frame is parsed after m_last.
- FIFO trickle (used=1, byte arriving every 3 cycles): never a double pop. Also: 300 consecutive bad frames leave err_count=8'hFF; reset asserted mid-PAYLOAD clears err_count=0 and all outputs are 0 the following cycle.
